// File: rtl/compare_round_ctrl.sv
// -----------------------------------------------------------------------------
// compare_round_ctrl
//
// Round sequencer for the pattern-compare datapath. Each round it loads a
// pseudo-random target pattern from a free-running LFSR, enables the
// comparator while the round is live, waits for the player to hold a matching
// pattern for MATCH_HOLD consecutive cycles, and keeps score / round count.
// In advance mode a per-round countdown runs and a timeout loses the game.
// In practice mode the countdown is frozen and rounds wrap forever.
//
// Ports:
//   clk          in   1      system clock, all logic on posedge
//   reset        in   1      synchronous, active-high
//   start        in   1      level; rising edge detected internally
//   advance      in   1      advance-mode switch
//   practicle    in   1      practice-mode switch
//   player_input in   WIDTH  player switch pattern
//   target       out  WIDTH  current round pattern to comparator
//   cmp_en       out  1      comparator enable, high only in PLAY/HOLD
//   time_left    out  6      remaining countdown ticks
//   score        out  4      rounds cleared, saturates at 15
//   round_num    out  4      current round, 1-based; 0 in IDLE
//   state_out    out  3      FSM state encoding (debug / checker hook)
//   win          out  1      high in WIN
//   lose         out  1      high in LOSE
//
// There is no valid/ready handshake on this block: all inputs are sampled
// levels and all outputs are registered state or direct decodes of it.
// -----------------------------------------------------------------------------
module compare_round_ctrl #(
    parameter int              WIDTH      = 10,
    parameter int              TICK_DIV   = 50000000,
    parameter int              ROUND_TIME = 30,
    parameter int              MAX_ROUNDS = 9,
    parameter int              MATCH_HOLD = 4,
    parameter logic [WIDTH-1:0] LFSR_SEED = 10'h2A5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             advance,
    input  logic             practicle,
    input  logic [WIDTH-1:0] player_input,
    output logic [WIDTH-1:0] target,
    output logic             cmp_en,
    output logic [5:0]       time_left,
    output logic [3:0]       score,
    output logic [3:0]       round_num,
    output logic [2:0]       state_out,
    output logic             win,
    output logic             lose
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_HOLD = 3'd3,
        S_WIN  = 3'd4,
        S_LOSE = 3'd5
    } state_t;

    state_t             state, state_nx;
    logic               start_q;
    logic               mode_adv, mode_adv_nx;
    logic [WIDTH-1:0]   lfsr, lfsr_nx;
    logic [WIDTH-1:0]   target_r, target_nx;
    logic [5:0]         time_r, time_nx;
    logic [3:0]         score_r, score_nx;
    logic [3:0]         round_r, round_nx;
    logic [PRE_W-1:0]   pre_r, pre_nx;
    logic [3:0]         hold_r, hold_nx;

    logic               start_edge;
    logic               mode_valid;
    logic               match;
    logic               round_clear;

    assign start_edge = start & ~start_q;
    assign mode_valid = advance | practicle;
    assign match      = (player_input == target_r);

    // Fibonacci LFSR, x^10 + x^7 + 1: feedback from bits 9 and 6.
    assign lfsr_nx = {lfsr[WIDTH-2:0], lfsr[WIDTH-1] ^ lfsr[6]};

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            mode_adv <= 1'b0;
            lfsr     <= LFSR_SEED;
            target_r <= '0;
            time_r   <= 6'(ROUND_TIME);
            score_r  <= 4'd0;
            round_r  <= 4'd0;
            pre_r    <= '0;
            hold_r   <= 4'd0;
        end else begin
            state    <= state_nx;
            start_q  <= start;
            mode_adv <= mode_adv_nx;
            lfsr     <= lfsr_nx;
            target_r <= target_nx;
            time_r   <= time_nx;
            score_r  <= score_nx;
            round_r  <= round_nx;
            pre_r    <= pre_nx;
            hold_r   <= hold_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        mode_adv_nx = mode_adv;
        target_nx   = target_r;
        time_nx     = time_r;
        score_nx    = score_r;
        round_nx    = round_r;
        pre_nx      = pre_r;
        hold_nx     = hold_r;
        round_clear = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_edge && mode_valid) begin
                    state_nx    = S_LOAD;
                    mode_adv_nx = advance;
                    round_nx    = 4'd1;
                    score_nx    = 4'd0;
                end
            end

            S_LOAD: begin
                // Flip the LSB if the fresh pattern already matches the
                // switches, so no round starts pre-cleared.
                if (lfsr == player_input) begin
                    target_nx = lfsr ^ WIDTH'(1);
                end else begin
                    target_nx = lfsr;
                end
                time_nx  = 6'(ROUND_TIME);
                pre_nx   = '0;
                hold_nx  = 4'd0;
                state_nx = S_PLAY;
            end

            S_PLAY, S_HOLD: begin
                if (match) begin
                    if (state == S_PLAY) begin
                        if (MATCH_HOLD == 1) begin
                            round_clear = 1'b1;
                        end else begin
                            hold_nx  = 4'd1;
                            state_nx = S_HOLD;
                        end
                    end else if ((hold_r + 4'd1) == 4'(MATCH_HOLD)) begin
                        round_clear = 1'b1;
                    end else begin
                        hold_nx = hold_r + 4'd1;
                    end
                end else if (state == S_HOLD) begin
                    hold_nx  = 4'd0;
                    state_nx = S_PLAY;
                end

                if (round_clear) begin
                    // Clearing takes priority over a coincident final tick:
                    // the countdown is left untouched this cycle.
                    hold_nx  = 4'd0;
                    score_nx = (score_r == 4'd15) ? 4'd15 : score_r + 4'd1;
                    if (mode_adv && (round_r == 4'(MAX_ROUNDS))) begin
                        state_nx = S_WIN;
                    end else begin
                        state_nx = S_LOAD;
                        if (!mode_adv && (round_r == 4'(MAX_ROUNDS))) begin
                            round_nx = 4'd1;
                        end else begin
                            round_nx = round_r + 4'd1;
                        end
                    end
                end else if (mode_adv) begin
                    if (pre_r == PRE_W'(TICK_DIV - 1)) begin
                        pre_nx  = '0;
                        time_nx = time_r - 6'd1;
                        if (time_r == 6'd1) begin
                            state_nx = S_LOSE;
                        end
                    end else begin
                        pre_nx = pre_r + PRE_W'(1);
                    end
                end
            end

            S_WIN, S_LOSE: begin
                if (start_edge) begin
                    state_nx    = S_LOAD;
                    mode_adv_nx = advance;
                    round_nx    = 4'd1;
                    score_nx    = 4'd0;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Both mode switches off abandons whatever is in progress.
        if ((state != S_IDLE) && !mode_valid) begin
            state_nx = S_IDLE;
            round_nx = 4'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign target    = target_r;
    assign cmp_en    = (state == S_PLAY) || (state == S_HOLD);
    assign time_left = time_r;
    assign score     = score_r;
    assign round_num = round_r;
    assign state_out = state;
    assign win       = (state == S_WIN);
    assign lose      = (state == S_LOSE);

endmodule

// File: tb/tb_compare_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_compare_round_ctrl
//
// Directed bench for compare_round_ctrl with small timing parameters
// (TICK_DIV=4, ROUND_TIME=3, MAX_ROUNDS=2, MATCH_HOLD=2). A reference LFSR
// predicts each round's target; predictions are queued when a round is
// loaded and popped when the DUT enters PLAY.
// -----------------------------------------------------------------------------
module tb_compare_round_ctrl;

  localparam int         W     = 10;
  localparam logic [9:0] SEED  = 10'h2A5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PLAY = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_WIN  = 3'd4;
  localparam logic [2:0] ST_LOSE = 3'd5;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         advance;
  logic         practicle;
  logic [W-1:0] player_input;
  logic [W-1:0] target;
  logic         cmp_en;
  logic [5:0]   time_left;
  logic [3:0]   score;
  logic [3:0]   round_num;
  logic [2:0]   state_out;
  logic         win;
  logic         lose;

  always #5 clk = ~clk;

  compare_round_ctrl #(
    .WIDTH      (W),
    .TICK_DIV   (4),
    .ROUND_TIME (3),
    .MAX_ROUNDS (2),
    .MATCH_HOLD (2),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .advance      (advance),
    .practicle    (practicle),
    .player_input (player_input),
    .target       (target),
    .cmp_en       (cmp_en),
    .time_left    (time_left),
    .score        (score),
    .round_num    (round_num),
    .state_out    (state_out),
    .win          (win),
    .lose         (lose)
  );

  // Reference x^10+x^7+1 LFSR, free-running like the design's.
  logic [W-1:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  // ------------------------------------------------------------------ scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_t;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_target();
    logic [W-1:0] one;
    one = 10'h001;
    if (m_lfsr == player_input) exp_q.push_back(m_lfsr ^ one);
    else                        exp_q.push_back(m_lfsr);
  endtask

  task automatic check_target(input string tag);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed %0h expected <none queued>", tag, target);
    end else begin
      last_t = exp_q.pop_front();
      chk(tag, 32'(target), 32'(last_t));
    end
  endtask

  // --------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    start        = 1'b0;
    advance      = 1'b0;
    practicle    = 1'b0;
    player_input = '0;
    tick();
    tick();
    exp_q.delete();
  endtask

  task automatic start_game(input string tag, output logic [W-1:0] t);
    start = 1'b1;
    tick();
    chk({tag, "_load"}, 32'(state_out), 32'(ST_LOAD));
    push_target();
    start = 1'b0;
    tick();
    chk({tag, "_play"}, 32'(state_out), 32'(ST_PLAY));
    chk({tag, "_cmp_en"}, 32'(cmp_en), 32'd1);
    check_target({tag, "_target"});
    t = last_t;
  endtask

  // Called with the DUT in LOAD after a clear; returns the new target.
  task automatic next_round(input string tag, output logic [W-1:0] t);
    push_target();
    tick();
    chk({tag, "_play"}, 32'(state_out), 32'(ST_PLAY));
    check_target({tag, "_target"});
    t = last_t;
  endtask

  task automatic match_clear(input string tag, input logic [W-1:0] t);
    player_input = t;
    tick();
    chk({tag, "_hold"}, 32'(state_out), 32'(ST_HOLD));
    tick();
  endtask

  function automatic logic [W-1:0] miss(input logic [W-1:0] t);
    return t ^ W'($urandom_range(1, 1023));
  endfunction

  // ------------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------------- sequence
  initial begin
    logic [W-1:0] t;

    // Reset values (checked while reset is still asserted).
    do_reset();
    chk("rst_state", 32'(state_out), 32'(ST_IDLE));
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_cmp_en", 32'(cmp_en), 32'd0);
    chk("rst_time", 32'(time_left), 32'd3);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_round", 32'(round_num), 32'd0);
    chk("rst_win_lose", 32'({win, lose}), 32'd0);
    reset = 1'b0;

    // 1: advance game, clear both rounds -> WIN.
    advance = 1'b1;
    start_game("t1_r1", t);
    chk("t1_round1", 32'(round_num), 32'd1);
    match_clear("t1_c1", t);
    chk("t1_c1_state", 32'(state_out), 32'(ST_LOAD));
    chk("t1_c1_round", 32'(round_num), 32'd2);
    chk("t1_c1_score", 32'(score), 32'd1);
    player_input = miss(t);
    next_round("t1_r2", t);
    match_clear("t1_c2", t);
    chk("t1_win_state", 32'(state_out), 32'(ST_WIN));
    chk("t1_win", 32'(win), 32'd1);
    chk("t1_win_score", 32'(score), 32'd2);
    chk("t1_win_round", 32'(round_num), 32'd2);
    chk("t1_win_cmp_en", 32'(cmp_en), 32'd0);
    tick();
    chk("t1_win_target_held", 32'(target), 32'(t));

    // 2: advance game, never match -> LOSE 12 clk after entering PLAY.
    do_reset();
    reset   = 1'b0;
    advance = 1'b1;
    start_game("t2", t);
    chk("t2_time3", 32'(time_left), 32'd3);
    player_input = miss(t);
    repeat (4) tick();
    chk("t2_time2", 32'(time_left), 32'd2);
    repeat (4) tick();
    chk("t2_time1", 32'(time_left), 32'd1);
    repeat (3) tick();
    chk("t2_still_play", 32'(state_out), 32'(ST_PLAY));
    tick();
    chk("t2_lose_state", 32'(state_out), 32'(ST_LOSE));
    chk("t2_lose", 32'(lose), 32'd1);
    chk("t2_lose_cmp_en", 32'(cmp_en), 32'd0);

    // 3: practice mode, three clears -> rounds 1,2,1,2, timer frozen.
    do_reset();
    reset     = 1'b0;
    practicle = 1'b1;
    start_game("t3_r1", t);
    chk("t3_round_a", 32'(round_num), 32'd1);
    match_clear("t3_c1", t);
    chk("t3_round_b", 32'(round_num), 32'd2);
    next_round("t3_r2", t);
    player_input = miss(t);
    repeat (10) tick();
    chk("t3_time_frozen", 32'(time_left), 32'd3);
    chk("t3_no_timeout", 32'(state_out), 32'(ST_PLAY));
    match_clear("t3_c2", t);
    chk("t3_round_c", 32'(round_num), 32'd1);
    chk("t3_score2", 32'(score), 32'd2);
    next_round("t3_r3", t);
    match_clear("t3_c3", t);
    chk("t3_round_d", 32'(round_num), 32'd2);
    chk("t3_score3", 32'(score), 32'd3);
    chk("t3_no_win_lose", 32'({win, lose}), 32'd0);

    // 4: broken match stretches do not clear; a full stretch does.
    do_reset();
    reset   = 1'b0;
    advance = 1'b1;
    start_game("t4", t);
    repeat (2) begin
      player_input = t;
      tick();
      chk("t4_hold", 32'(state_out), 32'(ST_HOLD));
      player_input = miss(t);
      tick();
      chk("t4_back_play", 32'(state_out), 32'(ST_PLAY));
    end
    chk("t4_score0", 32'(score), 32'd0);
    match_clear("t4_c", t);
    chk("t4_score1", 32'(score), 32'd1);
    chk("t4_load", 32'(state_out), 32'(ST_LOAD));

    // 5: mode dropout mid-PLAY, then reset during HOLD.
    do_reset();
    reset   = 1'b0;
    advance = 1'b1;
    start_game("t5", t);
    advance = 1'b0;
    tick();
    chk("t5_drop_state", 32'(state_out), 32'(ST_IDLE));
    chk("t5_drop_cmp_en", 32'(cmp_en), 32'd0);
    chk("t5_drop_round", 32'(round_num), 32'd0);
    advance = 1'b1;
    start_game("t5b", t);
    player_input = t;
    tick();
    chk("t5_hold", 32'(state_out), 32'(ST_HOLD));
    reset = 1'b1;
    tick();
    chk("t5_rst_state", 32'(state_out), 32'(ST_IDLE));
    chk("t5_rst_target", 32'(target), 32'd0);
    chk("t5_rst_score", 32'(score), 32'd0);
    chk("t5_rst_round", 32'(round_num), 32'd0);
    chk("t5_rst_time", 32'(time_left), 32'd3);
    chk("t5_rst_cmp_en", 32'(cmp_en), 32'd0);
    reset = 1'b0;

    // 6: final-round clear coincides with the last tick -> WIN.
    do_reset();
    reset   = 1'b0;
    advance = 1'b1;
    start_game("t6_r1", t);
    match_clear("t6_c1", t);
    player_input = miss(t);
    next_round("t6_r2", t);
    player_input = miss(t);
    repeat (10) tick();
    chk("t6_time1", 32'(time_left), 32'd1);
    player_input = t;
    tick();
    chk("t6_hold", 32'(state_out), 32'(ST_HOLD));
    tick();
    chk("t6_win_state", 32'(state_out), 32'(ST_WIN));
    chk("t6_not_lose", 32'(lose), 32'd0);
    chk("t6_time_kept", 32'(time_left), 32'd1);
    chk("t6_score", 32'(score), 32'd2);

    // 6b: start edge with both modes off is ignored.
    do_reset();
    reset = 1'b0;
    start = 1'b1;
    tick();
    chk("t6b_idle_a", 32'(state_out), 32'(ST_IDLE));
    start = 1'b0;
    tick();
    chk("t6b_idle_b", 32'(state_out), 32'(ST_IDLE));
    chk("t6b_round", 32'(round_num), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
